// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART TX scheduler slice.
package uart_tx_scheduler_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned LEN_W     = 3;
    localparam int unsigned SHIFT_W   = 40;
    localparam int unsigned MAX_BYTES = 4;

    // Byte-sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

    // Frame source ids, also the bit index into the req/grant vectors
    localparam logic SRC_CMD = 1'b0;
    localparam logic SRC_EVT = 1'b1;

    // Serial command opcodes
    localparam logic [BYTE_W-1:0] CMD_SCORE = 8'h07;

    // Frame offered by a source
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } frame_t;

    // Payload lengths above four bytes are treated as four
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the source that did not win last.
module rr_arb2
    import uart_tx_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant_c,
    output logic       grant_id_c
);

    logic last_grant;

    // Pick the winner from the current requests and the previous winner
    always_comb begin
        grant_c    = 2'b00;
        grant_id_c = SRC_CMD;
        unique case (req)
            2'b01:   grant_id_c = SRC_CMD;
            2'b10:   grant_id_c = SRC_EVT;
            2'b11:   grant_id_c = ~last_grant;
            default: grant_id_c = SRC_CMD;
        endcase
        if (req != 2'b00) begin
            grant_c = (grant_id_c == SRC_EVT) ? 2'b10 : 2'b01;
        end
    end

    // Remember the last winner; after reset the command path wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= SRC_EVT;
        end else if (grant_en && (req != 2'b00)) begin
            last_grant <= grant_id_c;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between the command-reply and event frame sources.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT = 8,
    parameter bit          EVT_TAG_EN   = 1'b1,
    parameter logic [7:0]  EVT_TAG      = 8'hE0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_ack,
    input  logic              evt_valid,
    input  logic [DATA_W-1:0] evt_data,
    input  logic [LEN_W-1:0]  evt_len,
    output logic              evt_ack,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    sched_state_e       state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]   bytes_left_q, bytes_left_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_ready_q;

    logic               cmd_ack_d, evt_ack_d, tx_start_d, busy_d, timeout_err_d;
    logic [BYTE_W-1:0]  tx_data_d;

    logic [1:0]         req_c, grant_c;
    logic               grant_id_c, grant_en_c;
    frame_t             sel_c;
    logic               tag_c;
    logic [LEN_W-1:0]   nbytes_c;

    // A source is not re-accepted in the cycle its ack is showing
    assign req_c      = {evt_valid & ~evt_ack, cmd_valid & ~cmd_ack};
    assign grant_en_c = (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req_c),
        .grant_en   (grant_en_c),
        .grant_c    (grant_c),
        .grant_id_c (grant_id_c)
    );

    // Next-state and next-output logic for the byte sequencer
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bytes_left_d  = bytes_left_q;
        cnt_d         = cnt_q;
        cmd_ack_d     = 1'b0;
        evt_ack_d     = 1'b0;
        tx_start_d    = tx_start;
        tx_data_d     = tx_data;
        busy_d        = busy;
        timeout_err_d = timeout_err;
        sel_c         = '0;
        tag_c         = 1'b0;
        nbytes_c      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_c != 2'b00) begin
                    if (grant_id_c == SRC_EVT) begin
                        sel_c = '{data: evt_data, len: clamp_len(evt_len)};
                        tag_c = EVT_TAG_EN;
                    end else begin
                        sel_c = '{data: cmd_data, len: clamp_len(cmd_len)};
                    end
                    cmd_ack_d    = grant_c[0];
                    evt_ack_d    = grant_c[1];
                    nbytes_c     = sel_c.len + LEN_W'(tag_c);
                    shift_d      = tag_c ? {EVT_TAG, sel_c.data} : {sel_c.data, 8'h00};
                    bytes_left_d = nbytes_c;
                    // An empty frame is acknowledged without touching uart_tx
                    if (nbytes_c != '0) begin
                        busy_d  = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (tx_ready) begin
                    tx_data_d  = shift_q[SHIFT_W-1 -: BYTE_W];
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!tx_ready && last_ready_q) begin
                    tx_start_d   = 1'b0;
                    shift_d      = {shift_q[SHIFT_W-BYTE_W-1:0], 8'h00};
                    bytes_left_d = bytes_left_q - LEN_W'(1);
                    state_d      = ST_DRAIN;
                end else if (cnt_d == CNT_W'(BUSY_TIMEOUT)) begin
                    // uart_tx never took the byte: abandon the rest of the frame
                    tx_start_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    bytes_left_d  = '0;
                    shift_d       = '0;
                    state_d       = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                if (tx_ready) begin
                    if (bytes_left_q == '0) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bytes_left_q <= '0;
            cnt_q        <= '0;
            last_ready_q <= 1'b0;
            cmd_ack      <= 1'b0;
            evt_ack      <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bytes_left_q <= bytes_left_d;
            cnt_q        <= cnt_d;
            last_ready_q <= tx_ready;
            cmd_ack      <= cmd_ack_d;
            evt_ack      <= evt_ack_d;
            tx_start     <= tx_start_d;
            tx_data      <= tx_data_d;
            busy         <= busy_d;
            timeout_err  <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a behavioural uart_tx stand-in.
module tb_uart_tx_scheduler;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data  = '0;
    logic [2:0]  cmd_len   = '0;
    logic        cmd_ack;
    logic        evt_valid = 1'b0;
    logic [31:0] evt_data  = '0;
    logic [2:0]  evt_len   = '0;
    logic        evt_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready  = 1'b1;
    logic        busy;
    logic        timeout_err;

    int tests    = 0;
    int fails    = 0;
    int starts   = 0;
    int cmd_acks = 0;
    int evt_acks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic       hang = 1'b0;

    typedef struct {
        logic        is_evt;
        logic [31:0] data;
        logic [2:0]  len;
        int          exp_starts;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[5];

    uart_tx_scheduler #(
        .BUSY_TIMEOUT (8),
        .EVT_TAG_EN   (1'b1),
        .EVT_TAG      (8'hE0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_len     (cmd_len),
        .cmd_ack     (cmd_ack),
        .evt_valid   (evt_valid),
        .evt_data    (evt_data),
        .evt_len     (evt_len),
        .evt_ack     (evt_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: ready falls 2 cycles after start, returns 10 cycles later
    logic [1:0] m_st = 2'd0;
    int         m_n  = 0;
    always @(posedge clk) begin
        if (reset) begin
            tx_ready <= 1'b1;
            m_st     <= 2'd0;
            m_n      <= 0;
        end else begin
            case (m_st)
                2'd0: if (tx_start && !hang) m_st <= 2'd1;
                2'd1: begin tx_ready <= 1'b0; m_n <= 9; m_st <= 2'd2; end
                default: begin
                    if (m_n == 0) begin tx_ready <= 1'b1; m_st <= 2'd0; end
                    else m_n <= m_n - 1;
                end
            endcase
        end
    end

    // Scoreboard and protocol monitor
    logic       p_start = 1'b0, p_busy = 1'b0, p_cack = 1'b0, p_eack = 1'b0;
    logic [7:0] p_data  = '0;
    always @(negedge clk) begin
        if (tx_start && !p_start) begin
            starts++;
            tests++;
            if (!tx_ready) begin
                fails++;
                $display("FAIL start_ready: tx_start rose with tx_ready=%0b, required 1", tx_ready);
            end
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tx_byte: got %02h, required no byte", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    fails++;
                    $display("FAIL tx_byte: got %02h, required %02h", tx_data, exp_b);
                end
            end
        end
        if (tx_start && p_start) begin
            tests++;
            if (tx_data !== p_data) begin
                fails++;
                $display("FAIL tx_data_stable: got %02h, required %02h", tx_data, p_data);
            end
        end
        if (cmd_ack) begin
            cmd_acks++;
            tests++;
            if (!cmd_valid || p_cack || p_busy) begin
                fails++;
                $display("FAIL cmd_ack_rule: valid=%0b prev_ack=%0b prev_busy=%0b, required 1/0/0",
                         cmd_valid, p_cack, p_busy);
            end
        end
        if (evt_ack) begin
            evt_acks++;
            tests++;
            if (!evt_valid || p_eack || p_busy) begin
                fails++;
                $display("FAIL evt_ack_rule: valid=%0b prev_ack=%0b prev_busy=%0b, required 1/0/0",
                         evt_valid, p_eack, p_busy);
            end
        end
        p_start = tx_start;
        p_data  = tx_data;
        p_busy  = busy;
        p_cack  = cmd_ack;
        p_eack  = evt_ack;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Expected uart byte stream for one frame
    function automatic void push_exp(input logic is_evt, input logic [31:0] d, input logic [2:0] len);
        int n;
        n = (len > 3'd4) ? 4 : int'(len);
        if (is_evt) exp_q.push_back(8'hE0);
        for (int i = 0; i < n; i++) exp_q.push_back(d[31-8*i -: 8]);
    endfunction

    // Offer a frame and wait (bounded) for its ack; valid is left high
    task automatic offer(input logic is_evt, input logic [31:0] d, input logic [2:0] len);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        if (is_evt) begin evt_data = d; evt_len = len; evt_valid = 1'b1; end
        else        begin cmd_data = d; cmd_len = len; cmd_valid = 1'b1; end
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            got = is_evt ? evt_ack : cmd_ack;
        end
        check(is_evt ? "evt_ack_seen" : "cmd_ack_seen", 32'(got), 32'd1);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    int s0, a0, n;

    initial begin
        vecs[0] = '{1'b0, 32'h00030290, 3'd4, 4, 1'b1};
        vecs[1] = '{1'b1, 32'h12345678, 3'd2, 3, 1'b1};
        vecs[2] = '{1'b0, 32'hDEADBEEF, 3'd0, 0, 1'b0};
        vecs[3] = '{1'b0, 32'hCAFEF00D, 3'd7, 4, 1'b1};
        vecs[4] = '{1'b1, 32'hA5A5A5A5, 3'd0, 1, 1'b1};

        // Both sources held from reset: round-robin order CMD, EVT, CMD, EVT
        cmd_data = 32'hC1000000; cmd_len = 3'd1; cmd_valid = 1'b1;
        evt_data = 32'hB1000000; evt_len = 3'd1; evt_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({tx_start, busy, timeout_err, cmd_ack, evt_ack, tx_data}), 32'd0);
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hE0); exp_q.push_back(8'hB1);
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'hE0); exp_q.push_back(8'hB2);
        s0 = starts;
        reset = 1'b0;
        fork
            begin
                offer(1'b0, 32'hC1000000, 3'd1);
                offer(1'b0, 32'hC2000000, 3'd1);
                cmd_valid = 1'b0;
            end
            begin
                offer(1'b1, 32'hB1000000, 3'd1);
                offer(1'b1, 32'hB2000000, 3'd1);
                evt_valid = 1'b0;
            end
        join
        wait_idle("rr_idle");
        check("rr_starts", 32'(starts - s0), 32'd6);
        check("rr_queue_left", 32'(exp_q.size()), 32'd0);
        check("rr_cmd_acks", 32'(cmd_acks), 32'd2);
        check("rr_evt_acks", 32'(evt_acks), 32'd2);

        // Single-frame vectors
        for (int i = 0; i < 5; i++) begin
            s0 = starts;
            a0 = vecs[i].is_evt ? evt_acks : cmd_acks;
            push_exp(vecs[i].is_evt, vecs[i].data, vecs[i].len);
            offer(vecs[i].is_evt, vecs[i].data, vecs[i].len);
            check($sformatf("v%0d_busy_at_ack", i), 32'(busy), 32'(vecs[i].exp_busy));
            if (vecs[i].is_evt) evt_valid = 1'b0; else cmd_valid = 1'b0;
            wait_idle($sformatf("v%0d_idle", i));
            check($sformatf("v%0d_starts", i), 32'(starts - s0), 32'(vecs[i].exp_starts));
            check($sformatf("v%0d_acks", i),
                  32'((vecs[i].is_evt ? evt_acks : cmd_acks) - a0), 32'd1);
            check($sformatf("v%0d_queue_left", i), 32'(exp_q.size()), 32'd0);
            check($sformatf("v%0d_timeout_err", i), 32'(timeout_err), 32'd0);
        end

        // uart_tx never drops ready: frame abandoned after 8 cycles of tx_start
        hang = 1'b1;
        s0 = starts;
        exp_q.push_back(8'hAA);
        offer(1'b0, 32'hAABB0000, 3'd2);
        cmd_valid = 1'b0;
        n = 0;
        while (!tx_start && n < 50) begin @(negedge clk); n++; end
        check("to_start_seen", 32'(tx_start), 32'd1);
        n = 0;
        while (tx_start && n < 50) begin n++; @(negedge clk); end
        check("to_start_len", 32'(n), 32'd8);
        check("to_err_set", 32'(timeout_err), 32'd1);
        check("to_busy_low", 32'(busy), 32'd0);
        hang = 1'b0;
        repeat (20) @(negedge clk);
        check("to_starts", 32'(starts - s0), 32'd1);
        check("to_queue_left", 32'(exp_q.size()), 32'd0);
        push_exp(1'b1, 32'h5C000000, 3'd1);
        offer(1'b1, 32'h5C000000, 3'd1);
        evt_valid = 1'b0;
        wait_idle("to_next_idle");
        check("to_next_queue", 32'(exp_q.size()), 32'd0);
        check("to_err_sticky", 32'(timeout_err), 32'd1);

        // Reset during the third byte of a four-byte frame
        s0 = starts;
        push_exp(1'b0, 32'h11223344, 3'd4);
        offer(1'b0, 32'h11223344, 3'd4);
        cmd_valid = 1'b0;
        n = 0;
        while ((starts - s0) < 3 && n < 200) begin @(negedge clk); n++; end
        check("rst_third_byte", 32'(starts - s0), 32'd3);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_outputs", 32'({tx_start, busy, timeout_err, cmd_ack, evt_ack}), 32'd0);
        check("rst_bytes_lost", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        s0 = starts;
        push_exp(1'b0, 32'h99887766, 3'd2);
        offer(1'b0, 32'h99887766, 3'd2);
        cmd_valid = 1'b0;
        wait_idle("rst_next_idle");
        check("rst_next_starts", 32'(starts - s0), 32'd2);
        check("rst_next_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Runaway guard
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

endmodule
